// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - multi-cycle digit-serial subtractor with start/busy/done handshake
//
// Computes minuend - subtrahend - inborrow DIGIT bits per clock. The operands
// are captured into shift registers, the borrow is carried between cycles in a
// register, and each result digit enters the result register at the MSB end so
// the full difference is aligned after N = WIDTH/DIGIT compute cycles.

// Single full-subtractor cell: d = a - b - bi, bo = borrow out.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  input  logic             inborrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             outborrow,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  // An operand width that is not a whole number of digits has no meaning here.
  if (WIDTH < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $fatal(1, "serial_subtractor: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;

  logic [DIGIT:0]   bc;
  logic [DIGIT-1:0] dig;
  logic [WIDTH-1:0] dig_w;
  logic [WIDTH-1:0] res_next;

  // The registered borrow feeds the least significant cell of this digit.
  assign bc[0] = borrow;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    fs_cell u_cell (
      .a  (a_sr[i]),
      .b  (b_sr[i]),
      .bi (bc[i]),
      .d  (dig[i]),
      .bo (bc[i+1])
    );
  end

  // Place the new digit at the top of the result word; older digits move down.
  always_comb begin
    dig_w              = '0;
    dig_w[DIGIT-1:0]   = dig;
    res_next           = (res_sr >> DIGIT) | (dig_w << (WIDTH - DIGIT));
  end

  // Handshake FSM, datapath shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      outborrow <= 1'b0;
      overflow  <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= minuend;
            b_sr   <= subtrahend;
            borrow <= inborrow;
            a_msb  <= minuend[WIDTH-1];
            b_msb  <= subtrahend[WIDTH-1];
            res_sr <= '0;
            cnt    <= CW'(N);
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          borrow <= bc[DIGIT];
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            diff      <= res_next;
            outborrow <= bc[DIGIT];
            overflow  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor in three configurations
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // u0: WIDTH=8 DIGIT=1
  logic       s0, bi0, busy0, done0, ob0, ov0;
  logic [7:0] a0, b0, d0;
  // u1: WIDTH=8 DIGIT=4
  logic       s1, bi1, busy1, done1, ob1, ov1;
  logic [7:0] a1, b1, d1;
  // u2: WIDTH=1 DIGIT=1
  logic       s2, bi2, busy2, done2, ob2, ov2;
  logic [0:0] a2, b2, d2;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
    .clk(clk), .rst(rst), .start(s0), .minuend(a0), .subtrahend(b0), .inborrow(bi0),
    .busy(busy0), .done(done0), .diff(d0), .outborrow(ob0), .overflow(ov0));
  serial_subtractor #(.WIDTH(8), .DIGIT(4)) u1 (
    .clk(clk), .rst(rst), .start(s1), .minuend(a1), .subtrahend(b1), .inborrow(bi1),
    .busy(busy1), .done(done1), .diff(d1), .outborrow(ob1), .overflow(ov1));
  serial_subtractor #(.WIDTH(1), .DIGIT(1)) u2 (
    .clk(clk), .rst(rst), .start(s2), .minuend(a2), .subtrahend(b2), .inborrow(bi2),
    .busy(busy2), .done(done2), .diff(d2), .outborrow(ob2), .overflow(ov2));

  typedef struct {
    longint d;
    logic   ob;
    logic   ov;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s", name);
  endtask

  function automatic exp_t mk(input longint d, input logic ob, input logic ov);
    exp_t e;
    e.d  = d;
    e.ob = ob;
    e.ov = ov;
    return e;
  endfunction

  // Reference: plain integer subtraction, borrow = negative result, overflow from captured MSBs.
  function automatic exp_t model(input int w, input longint a, input longint b, input longint bi);
    exp_t   e;
    longint r, m;
    int     s;
    m    = longint'(1) << w;
    r    = a - b - bi;
    e.ob = (r < 0);
    if (r < 0) r = r + m;
    e.d  = r;
    s    = w - 1;
    e.ov = (((a >> s) & 1) != ((b >> s) & 1)) && (((r >> s) & 1) != ((a >> s) & 1));
    return e;
  endfunction

  // Monitors: pop the oldest expectation on every done pulse.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && done0) begin
      if (q0.size() == 0) flag_fail("w8d1 done with no pending operation");
      else begin
        e = q0.pop_front();
        chk("w8d1 diff", d0, e.d);
        chk("w8d1 outborrow", ob0, e.ob);
        chk("w8d1 overflow", ov0, e.ov);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) flag_fail("w8d4 done with no pending operation");
      else begin
        e = q1.pop_front();
        chk("w8d4 diff", d1, e.d);
        chk("w8d4 outborrow", ob1, e.ob);
        chk("w8d4 overflow", ov1, e.ov);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && done2) begin
      if (q2.size() == 0) flag_fail("w1d1 done with no pending operation");
      else begin
        e = q2.pop_front();
        chk("w1d1 diff", d2, e.d);
        chk("w1d1 outborrow", ob2, e.ob);
        chk("w1d1 overflow", ov2, e.ov);
      end
    end
  end

  // Wait (bounded) for done0 sampled just after a rising edge.
  task automatic wait_done0(input string name);
    for (int k = 0; k < 40 && !done0; k++) begin
      @(posedge clk); #1;
    end
    if (!done0) flag_fail({name, " timeout waiting for done"});
  endtask

  // One isolated operation on u0; returns with u0 idle, just after a rising edge.
  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic bi, input exp_t e);
    a0 = a; b0 = b; bi0 = bi; s0 = 1'b1;
    q0.push_back(e);
    @(posedge clk); #1;
    s0 = 1'b0;
    wait_done0("w8d1 op");
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int     n;
    logic [7:0] ra, rb;
    logic   rbi;

    rst = 1'b1;
    s0 = 0; a0 = 0; b0 = 0; bi0 = 0;
    s1 = 0; a1 = 0; b1 = 0; bi1 = 0;
    s2 = 0; a2 = 0; b2 = 0; bi2 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("reset busy", busy0, 0);
    chk("reset done", done0, 0);
    chk("reset diff", d0, 0);
    chk("reset outborrow", ob0, 0);
    chk("reset overflow", ov0, 0);
    chk("reset busy w8d4", busy1, 0);
    chk("reset busy w1d1", busy2, 0);

    // Latency: start in cycle 0, busy cycles 1..8, done in cycle 9.
    a0 = 8'h05; b0 = 8'h03; bi0 = 1'b0; s0 = 1'b1;
    q0.push_back(mk(64'h02, 1'b0, 1'b0));
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) s0 = 1'b0;
      chk($sformatf("latency busy cycle %0d", k), busy0, (k <= 8) ? 1 : 0);
      chk($sformatf("latency done cycle %0d", k), done0, (k == 9) ? 1 : 0);
    end
    @(posedge clk); #1;
    chk("done is a single pulse", done0, 0);

    // Directed boundary cases.
    op0(8'h00, 8'h01, 1'b0, mk(64'hFF, 1'b1, 1'b0));
    op0(8'h80, 8'h01, 1'b0, mk(64'h7F, 1'b0, 1'b1));
    op0(8'h00, 8'h00, 1'b1, mk(64'hFF, 1'b1, 1'b0));
    op0(8'h7F, 8'h80, 1'b0, mk(64'hFF, 1'b1, 1'b1));

    // Randomised operations against the arithmetic model.
    for (int j = 0; j < 20; j++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
      op0(ra, rb, rbi, model(8, ra, rb, rbi));
    end

    // Start held high through RUN with changed operands: first result unaffected,
    // the second operation is accepted from the done cycle.
    a0 = 8'h12; b0 = 8'h34; bi0 = 1'b1; s0 = 1'b1;
    q0.push_back(model(8, 8'h12, 8'h34, 1));
    @(posedge clk); #1;
    a0 = 8'h9A; b0 = 8'h0B; bi0 = 1'b0;
    q0.push_back(model(8, 8'h9A, 8'h0B, 0));
    wait_done0("w8d1 held start first");
    @(posedge clk); #1;
    s0 = 1'b0;
    chk("held start accepted in done cycle", busy0, 1);
    wait_done0("w8d1 held start second");
    @(posedge clk); #1;

    // Reset in cycle 4 of an operation: no done, outputs cleared, then a clean restart.
    a0 = 8'hC3; b0 = 8'h5A; bi0 = 1'b0; s0 = 1'b1;
    q0.push_back(model(8, 8'hC3, 8'h5A, 0));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) s0 = 1'b0;
    end
    rst = 1'b1;
    q0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", busy0, 0);
    chk("abort done", done0, 0);
    chk("abort diff", d0, 0);
    chk("abort outborrow", ob0, 0);
    chk("abort overflow", ov0, 0);
    repeat (12) @(posedge clk);
    #1;
    op0(8'h05, 8'h03, 1'b0, mk(64'h02, 1'b0, 1'b0));
    op0(8'h80, 8'h01, 1'b0, mk(64'h7F, 1'b0, 1'b1));

    // DIGIT=4: back-to-back starts from the done cycle, one result every 3 cycles.
    a1 = 8'h3C; b1 = 8'h5A; bi1 = 1'b0; s1 = 1'b1;
    q1.push_back(mk(64'hE2, 1'b1, 1'b0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done1 && n < 40);
    chk("w8d4 first done cycle", n, 3);
    for (int j = 0; j < 16; j++) begin
      if (j == 0) begin
        a1 = 8'h10; b1 = 8'h01; bi1 = 1'b0;
        q1.push_back(mk(64'h0F, 1'b0, 1'b0));
      end else begin
        a1 = 8'($urandom); b1 = 8'($urandom); bi1 = 1'($urandom);
        q1.push_back(model(8, a1, b1, bi1));
      end
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done1 && n < 40);
      chk("w8d4 done spacing", n, 3);
    end
    s1 = 1'b0;
    @(posedge clk); #1;

    // WIDTH=1: all eight full-subtractor input combinations, back to back.
    a2 = 1'b0; b2 = 1'b0; bi2 = 1'b0; s2 = 1'b1;
    q2.push_back(model(1, 0, 0, 0));
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done2 && n < 40);
    chk("w1d1 first done cycle", n, 2);
    for (int j = 1; j < 8; j++) begin
      a2 = 1'((j >> 2) & 1); b2 = 1'((j >> 1) & 1); bi2 = 1'(j & 1);
      q2.push_back(model(1, (j >> 2) & 1, (j >> 1) & 1, j & 1));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done2 && n < 40);
      chk("w1d1 done spacing", n, 2);
    end
    s2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("w8d1 results drained", q0.size(), 0);
    chk("w8d4 results drained", q1.size(), 0);
    chk("w1d1 results drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
